// File: rtl/vppm_pkg.sv
// Shared VPPM definitions for the transmit and receive paths: link state
// encoding, clock rate, framing defaults and the pulse-width calculation.
package vppm_pkg;

    localparam int unsigned CLK_FREQ          = 200_000_000;
    localparam int unsigned BIT_PERIOD_DEF    = 200;
    localparam int unsigned PREAMBLE_BITS_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF    = 8;
    localparam int unsigned DUTY_W            = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } vppm_state_e;

    // High time per symbol from an 8-bit duty; never 0 and never a full symbol
    function automatic int unsigned vppm_pulse_width(input int unsigned bit_period,
                                                     input logic [DUTY_W-1:0] duty);
        int unsigned w;
        w = (bit_period * 32'(duty)) >> DUTY_W;
        if (w == 0) begin
            w = 1;
        end else if (w >= bit_period) begin
            w = bit_period - 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vppm_symbol_shaper.sv
// Combinational line level for one VPPM symbol: '0' pulses at the start of
// the symbol, '1' pulses at the end, both lasting the latched width.
module vppm_symbol_shaper
    import vppm_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = BIT_PERIOD_DEF,
    parameter int unsigned CNT_W      = $clog2(BIT_PERIOD)
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] width,
    input  logic             sym_bit,
    input  logic             active,
    output logic             high_c
);

    localparam int unsigned CNT_XW = CNT_W + 1;

    logic [CNT_XW-1:0] late_start;

    always_comb begin
        late_start = CNT_XW'(BIT_PERIOD) - CNT_XW'(width);
        high_c     = 1'b0;
        if (active) begin
            high_c = sym_bit ? (CNT_XW'(cnt) >= late_start) : (cnt < width);
        end
    end

endmodule

// File: rtl/vppm_transmitter.sv
// VPPM transmitter: one-word holding register, preamble of '0' symbols, then
// MSB-first data symbols, back-to-back while words keep arriving.
module vppm_transmitter
    import vppm_pkg::*;
#(
    parameter int unsigned BIT_PERIOD    = BIT_PERIOD_DEF,
    parameter int unsigned PREAMBLE_BITS = PREAMBLE_BITS_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] txData,
    input  logic                  txValid,
    output logic                  txReady,
    input  logic [DUTY_W-1:0]     duty,
    output logic                  signalOut,
    output logic                  busy
);

    localparam int unsigned CNT_W    = $clog2(BIT_PERIOD);
    localparam int unsigned MAX_BITS = (PREAMBLE_BITS > DATA_WIDTH) ? PREAMBLE_BITS : DATA_WIDTH;
    localparam int unsigned BIT_W    = $clog2(MAX_BITS + 1);

    vppm_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      width_q, width_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_full_q, hold_full_d;
    logic                  signal_q, signal_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;

    logic                  load;
    logic                  accept;
    logic                  symbol_end;
    logic                  sym_bit;
    logic                  line_high_c;

    // Framing FSM: symbol counter, bit counter, width latch and shift register
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        width_d    = width_q;
        shift_d    = shift_q;
        load       = 1'b0;
        symbol_end = (cnt_q == CNT_W'(BIT_PERIOD - 1));

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (hold_full_q) begin
                    state_d   = ST_PREAMBLE;
                    width_d   = CNT_W'(vppm_pulse_width(BIT_PERIOD, duty));
                    bit_cnt_d = '0;
                end
            end
            ST_PREAMBLE: begin
                cnt_d = symbol_end ? '0 : cnt_q + CNT_W'(1);
                if (symbol_end) begin
                    if (bit_cnt_q == BIT_W'(PREAMBLE_BITS - 1)) begin
                        load      = 1'b1;
                        shift_d   = hold_data_q;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                cnt_d = symbol_end ? '0 : cnt_q + CNT_W'(1);
                if (symbol_end) begin
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            load    = 1'b1;
                            shift_d = hold_data_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d   = shift_q << 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register; a same-cycle accept wins over the load clearing it
    always_comb begin
        accept      = txValid && !hold_full_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = txData;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
        ready_d = !hold_full_d;
        busy_d  = (state_d != ST_IDLE);
    end

    assign sym_bit = (state_q == ST_DATA) ? shift_q[DATA_WIDTH-1] : 1'b0;

    vppm_symbol_shaper #(
        .BIT_PERIOD (BIT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_shaper (
        .cnt     (cnt_q),
        .width   (width_q),
        .sym_bit (sym_bit),
        .active  (state_q != ST_IDLE),
        .high_c  (line_high_c)
    );

    assign signal_d = line_high_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            width_q     <= '0;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            signal_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            width_q     <= width_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            signal_q    <= signal_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign signalOut = signal_q;
    assign busy      = busy_q;
    assign txReady   = ready_q;

endmodule

// File: tb/tb_vppm_transmitter.sv
// Directed bench for vppm_transmitter at BIT_PERIOD=10, PREAMBLE_BITS=2:
// each symbol's 10-cycle line pattern is compared with a hand-derived shape.
module tb_vppm_transmitter;

    localparam int BP = 10;
    localparam int PB = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] txData;
    logic          txValid;
    logic          txReady;
    logic [7:0]    duty;
    logic          signalOut;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vppm_transmitter #(
        .BIT_PERIOD    (BP),
        .PREAMBLE_BITS (PB),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .txData    (txData),
        .txValid   (txValid),
        .txReady   (txReady),
        .duty      (duty),
        .signalOut (signalOut),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line pattern of one symbol, bit i = cnt i, for the widths exercised here
    function automatic logic [9:0] sym_pat(input logic b, input int w);
        case (w)
            1:       return b ? 10'h200 : 10'h001;
            5:       return b ? 10'h3E0 : 10'h01F;
            9:       return b ? 10'h3FE : 10'h1FF;
            default: return 10'h000;
        endcase
    endfunction

    // Send w0 (and w1 during the first word when nwords==2), then sample one
    // full frame on negedges; s counts state cycles after the IDLE exit.
    task automatic run_frame(input logic [7:0] w0, input logic [7:0] w1, input int nwords,
                             input logic [7:0] dty, input int wexp, input bit disturb,
                             input int abort_s);
        int len, busy_cnt, sig_rises, rdy_rises, first_rise, second_rise, first_rdy, k, wi, pos;
        logic prev_sig, prev_rdy, b;
        logic [9:0] sv;
        logic [7:0] wd;
        len = (PB + DW * nwords) * BP;
        busy_cnt = 0; sig_rises = 0; rdy_rises = 0;
        first_rise = -1; second_rise = -1; first_rdy = -1;
        prev_sig = 1'b0; prev_rdy = 1'b0; sv = '0;

        duty = dty;
        @(negedge clk);
        check_eq("ready_idle", 32'(txReady), 32'd1);
        txValid = 1'b1;
        txData  = w0;
        @(negedge clk);
        txValid = 1'b0;
        check_eq("busy_pre", 32'(busy), 32'd0);

        for (int s = 0; s <= len; s++) begin
            @(negedge clk);
            if (s == abort_s) begin
                check_eq("pre_rst_high", 32'(signalOut), 32'd1);
                #2 reset = 1'b1;
                #1;
                check_eq("rst_sig", 32'(signalOut), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_ready", 32'(txReady), 32'd1);
                @(negedge clk);
                reset = 1'b0;
                repeat (4) @(negedge clk);
                check_eq("post_rst_idle", 32'(busy), 32'd0);
                return;
            end
            if (busy) busy_cnt++;
            if (txReady && !prev_rdy) begin
                if (rdy_rises == 0) first_rdy = s;
                rdy_rises++;
            end
            prev_rdy = txReady;
            if (s >= 1) begin
                k   = (s - 1) / BP;
                pos = (s - 1) % BP;
                sv[pos] = signalOut;
                if (k < PB && signalOut && !prev_sig) begin
                    if (sig_rises == 0) first_rise = s;
                    else if (sig_rises == 1) second_rise = s;
                    sig_rises++;
                end
                prev_sig = signalOut;
                if (pos == BP - 1) begin
                    if (k < PB) begin
                        b = 1'b0;
                    end else begin
                        wi = (k - PB) / DW;
                        wd = (wi == 0) ? w0 : w1;
                        b  = wd[DW - 1 - ((k - PB) % DW)];
                    end
                    check_eq($sformatf("sym%0d", k), 32'(sv), 32'(sym_pat(b, wexp)));
                end
            end
            if (nwords == 2 && s == 20) begin
                txValid = 1'b1;
                txData  = w1;
            end
            if (nwords == 2 && s == 21) txValid = 1'b0;
            if (disturb) begin
                if (s == 2) begin
                    txValid = 1'b1;
                    txData  = 8'h5A;
                end
                if (s == 3) txValid = 1'b0;
                if (s == 5) duty = 8'd26;
            end
        end

        check_eq("busy_cycles", 32'(busy_cnt), 32'(len));
        check_eq("ready_rises", 32'(rdy_rises), 32'(nwords));
        check_eq("ready_first", 32'(first_rdy), 32'(PB * BP));
        check_eq("pre_rises", 32'(sig_rises), 32'(PB));
        check_eq("first_high", 32'(first_rise), 32'd1);
        check_eq("pre_spacing", 32'(second_rise - first_rise), 32'(BP));
    endtask

    initial begin
        reset   = 1'b1;
        txValid = 1'b1;
        txData  = 8'h77;
        duty    = 8'd128;
        repeat (3) @(negedge clk);
        check_eq("rst_hold_sig", 32'(signalOut), 32'd0);
        check_eq("rst_hold_busy", 32'(busy), 32'd0);
        check_eq("rst_hold_ready", 32'(txReady), 32'd1);
        txValid = 1'b0;
        reset   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("no_frame", 32'(busy), 32'd0);

        run_frame(8'hA5, 8'h00, 1, 8'd128, 5, 1'b0, -1);
        run_frame(8'h00, 8'hFF, 2, 8'd128, 5, 1'b0, -1);
        run_frame(8'h0F, 8'h00, 1, 8'd0,   1, 1'b0, -1);
        run_frame(8'hF0, 8'h00, 1, 8'd255, 9, 1'b0, -1);

        run_frame(8'hC3, 8'h00, 1, 8'd128, 5, 1'b1, -1);
        repeat (3) @(negedge clk);
        check_eq("held_ignored", 32'(busy), 32'd0);

        run_frame(8'hA5, 8'h11, 2, 8'd128, 5, 1'b0, 52);
        run_frame(8'h3C, 8'h00, 1, 8'd128, 5, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
